// File: rtl/lfsr_seq_checker_if.sv
// Bus between an LFSR pattern source and the sequence checker: data word stream plus status.
interface lfsr_seq_checker_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       data_in;
  logic             data_valid;
  logic             clear_cnt;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output data_in, data_valid, clear_cnt,
    input  locked, error, err_count, state
  );

  modport slave (
    input  data_in, data_valid, clear_cnt,
    output locked, error, err_count, state
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising PRBS checker for x^8+x^6+x^5+x^4+1: seeds from the stream,
// verifies a run of matches, then flywheels and counts word errors until lock is lost.
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_seq_checker_if.slave bus
);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        expected_reg, expected_next;
  logic [RUN_W-1:0]  run_reg, run_next;
  logic [MISS_W-1:0] miss_reg, miss_next;
  logic              locked_reg, locked_next;
  logic              error_reg, error_next;
  logic [CNT_W-1:0]  err_count_reg, err_count_next;
  logic              count_hit;
  logic [RUN_W-1:0]  run_inc;
  logic [MISS_W-1:0] miss_inc;

  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

  assign run_inc  = run_reg + RUN_W'(1);
  assign miss_inc = miss_reg + MISS_W'(1);

  always_comb begin
    state_next     = state_reg;
    expected_next  = expected_reg;
    run_next       = run_reg;
    miss_next      = miss_reg;
    locked_next    = locked_reg;
    error_next     = 1'b0;
    count_hit      = 1'b0;
    err_count_next = err_count_reg;

    case (state_reg)
      SEARCH: begin
        // An all-zero word is the LFSR lockup state and cannot seed the sequence.
        if (bus.data_valid && bus.data_in != 8'h00) begin
          expected_next = lfsr_next(bus.data_in);
          run_next      = '0;
          state_next    = VERIFY;
        end
      end
      VERIFY: begin
        if (bus.data_valid) begin
          if (bus.data_in == expected_reg) begin
            expected_next = lfsr_next(expected_reg);
            run_next      = run_inc;
            if (run_inc == RUN_W'(LOCK_COUNT)) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
              miss_next   = '0;
            end
          end else if (bus.data_in != 8'h00) begin
            expected_next = lfsr_next(bus.data_in);
            run_next      = '0;
          end else begin
            run_next   = '0;
            state_next = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (bus.data_valid) begin
          expected_next = lfsr_next(expected_reg);
          if (bus.data_in == expected_reg) begin
            miss_next = '0;
          end else begin
            error_next = 1'b1;
            count_hit  = 1'b1;
            miss_next  = miss_inc;
            if (miss_inc == MISS_W'(LOSS_COUNT)) begin
              state_next  = SEARCH;
              locked_next = 1'b0;
              miss_next   = '0;
            end
          end
        end
      end
      default: begin
        state_next  = SEARCH;
        locked_next = 1'b0;
        run_next    = '0;
        miss_next   = '0;
      end
    endcase

    // Clear wins over a coincident increment; the error pulse itself is untouched.
    if (bus.clear_cnt) begin
      err_count_next = '0;
    end else if (count_hit && err_count_reg != {CNT_W{1'b1}}) begin
      err_count_next = err_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= SEARCH;
      expected_reg  <= '0;
      run_reg       <= '0;
      miss_reg      <= '0;
      locked_reg    <= 1'b0;
      error_reg     <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      expected_reg  <= expected_next;
      run_reg       <= run_next;
      miss_reg      <= miss_next;
      locked_reg    <= locked_next;
      error_reg     <= error_next;
      err_count_reg <= err_count_next;
    end
  end

  assign bus.locked    = locked_reg;
  assign bus.error     = error_reg;
  assign bus.err_count = err_count_reg;
  assign bus.state     = state_reg;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: a 16-bit-counter instance for lock/error/loss
// scenarios and a 2-bit-counter instance for saturation, clear priority and async reset.
module tb_lfsr_seq_checker;
  logic clk;
  logic reset;
  int   total;
  int   passed;

  lfsr_seq_checker_if #(.CNT_W(16)) bus ();
  lfsr_seq_checker_if #(.CNT_W(2))  bus2 ();

  lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] d, input logic v, input logic c);
    @(negedge clk);
    bus.data_in    = d;
    bus.data_valid = v;
    bus.clear_cnt  = c;
    @(posedge clk);
    #1;
    $display("tx dut  data=%h valid=%b clr=%b -> state=%b locked=%b error=%b cnt=%0d",
             d, v, c, bus.state, bus.locked, bus.error, bus.err_count);
  endtask

  task automatic drive2(input logic [7:0] d, input logic v, input logic c);
    @(negedge clk);
    bus2.data_in    = d;
    bus2.data_valid = v;
    bus2.clear_cnt  = c;
    @(posedge clk);
    #1;
    $display("tx dut2 data=%h valid=%b clr=%b -> state=%b locked=%b error=%b cnt=%0d",
             d, v, c, bus2.state, bus2.locked, bus2.error, bus2.err_count);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_in = 8'h00;  bus.data_valid = 1'b0;  bus.clear_cnt = 1'b0;
    bus2.data_in = 8'h00; bus2.data_valid = 1'b0; bus2.clear_cnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got %b want 0", bus.locked); else passed++;
    total++; if (bus.state !== 2'b00) $display("FAIL reset_state got %b want 00", bus.state); else passed++;
    total++; if (bus.err_count !== 16'd0) $display("FAIL reset_cnt got %0d want 0", bus.err_count); else passed++;
    total++; if (bus.error !== 1'b0) $display("FAIL reset_error got %b want 0", bus.error); else passed++;
    total++; if (bus2.err_count !== 2'd0) $display("FAIL reset_cnt2 got %0d want 0", bus2.err_count); else passed++;
  endtask

  task automatic test_lock();
    logic [7:0] data [5]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic [1:0] exp_st [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic       exp_lk [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(data[i], 1'b1, 1'b0);
      total++; if (bus.state !== exp_st[i]) $display("FAIL lock_state[%0d] got %b want %b", i, bus.state, exp_st[i]); else passed++;
      total++; if (bus.locked !== exp_lk[i]) $display("FAIL lock_locked[%0d] got %b want %b", i, bus.locked, exp_lk[i]); else passed++;
    end
    total++; if (bus.err_count !== 16'd0) $display("FAIL lock_cnt got %0d want 0", bus.err_count); else passed++;
  endtask

  task automatic test_single_error();
    drive(8'h23, 1'b1, 1'b0);
    total++; if (bus.error !== 1'b0) $display("FAIL single_good_err got %b want 0", bus.error); else passed++;
    drive(8'h24, 1'b1, 1'b0);
    total++; if (bus.error !== 1'b1) $display("FAIL single_bad_err got %b want 1", bus.error); else passed++;
    total++; if (bus.err_count !== 16'd1) $display("FAIL single_bad_cnt got %0d want 1", bus.err_count); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL single_bad_locked got %b want 1", bus.locked); else passed++;
    drive(8'h8E, 1'b1, 1'b0);
    total++; if (bus.error !== 1'b0) $display("FAIL single_after_err got %b want 0", bus.error); else passed++;
    total++; if (bus.err_count !== 16'd1) $display("FAIL single_after_cnt got %0d want 1", bus.err_count); else passed++;
  endtask

  task automatic test_loss_of_lock();
    drive(8'h00, 1'b0, 1'b1);
    total++; if (bus.err_count !== 16'd0) $display("FAIL clear_cnt got %0d want 0", bus.err_count); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL clear_locked got %b want 1", bus.locked); else passed++;
    // Expected stream here is 1C, 38, 71; every word sent is wrong.
    for (int i = 1; i <= 3; i++) begin
      drive(8'h00, 1'b1, 1'b0);
      total++; if (bus.error !== 1'b1) $display("FAIL loss_err[%0d] got %b want 1", i, bus.error); else passed++;
      total++; if (bus.err_count !== 16'(i)) $display("FAIL loss_cnt[%0d] got %0d want %0d", i, bus.err_count, i); else passed++;
      total++; if (bus.locked !== (i < 3)) $display("FAIL loss_locked[%0d] got %b want %b", i, bus.locked, (i < 3)); else passed++;
    end
    total++; if (bus.state !== 2'b00) $display("FAIL loss_state got %b want 00", bus.state); else passed++;
  endtask

  task automatic test_reseed();
    logic [7:0] data [8]   = '{8'h01, 8'h00, 8'h01, 8'h47, 8'h8E, 8'h1C, 8'h38, 8'h71};
    logic [1:0] exp_st [8] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) begin
      drive(data[i], 1'b1, 1'b0);
      total++; if (bus.state !== exp_st[i]) $display("FAIL reseed_state[%0d] got %b want %b", i, bus.state, exp_st[i]); else passed++;
    end
    total++; if (bus.error !== 1'b0) $display("FAIL reseed_err got %b want 0", bus.error); else passed++;
    repeat (3) drive(8'h00, 1'b1, 1'b0);
    total++; if (bus.state !== 2'b00) $display("FAIL reseed_drop got %b want 00", bus.state); else passed++;
  endtask

  task automatic test_search_and_gap();
    logic [7:0] data [10]  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h55, 8'h55, 8'h55, 8'h08, 8'h11};
    logic       vld [10]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_st [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 10; i++) begin
      drive(data[i], vld[i], 1'b0);
      total++; if (bus.state !== exp_st[i]) $display("FAIL gap_state[%0d] got %b want %b", i, bus.state, exp_st[i]); else passed++;
    end
    total++; if (bus.locked !== 1'b1) $display("FAIL gap_locked got %b want 1", bus.locked); else passed++;
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_saturate_clear_reset();
    logic [7:0] lock_seq [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    // Expected stream: 23,47,8E,1C,38,71,E2,C4,89; FF replaces every other word.
    logic [7:0] data [9]    = '{8'hFF, 8'h47, 8'hFF, 8'h1C, 8'hFF, 8'h71, 8'hFF, 8'hC4, 8'hFF};
    logic [1:0] exp_cnt [9] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic       exp_err [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) drive2(lock_seq[i], 1'b1, 1'b0);
    total++; if (bus2.locked !== 1'b1) $display("FAIL sat_lock got %b want 1", bus2.locked); else passed++;
    for (int i = 0; i < 9; i++) begin
      drive2(data[i], 1'b1, 1'b0);
      total++; if (bus2.err_count !== exp_cnt[i]) $display("FAIL sat_cnt[%0d] got %0d want %0d", i, bus2.err_count, exp_cnt[i]); else passed++;
      total++; if (bus2.error !== exp_err[i]) $display("FAIL sat_err[%0d] got %b want %b", i, bus2.error, exp_err[i]); else passed++;
    end
    drive2(8'hFF, 1'b1, 1'b1);
    total++; if (bus2.err_count !== 2'd0) $display("FAIL clr_prio_cnt got %0d want 0", bus2.err_count); else passed++;
    total++; if (bus2.error !== 1'b1) $display("FAIL clr_prio_err got %b want 1", bus2.error); else passed++;
    drive2(8'h25, 1'b1, 1'b0);
    total++; if (bus2.error !== 1'b0) $display("FAIL post_clr_err got %b want 0", bus2.error); else passed++;
    drive2(8'hFF, 1'b1, 1'b0);
    total++; if (bus2.err_count !== 2'd1) $display("FAIL pre_rst_cnt got %0d want 1", bus2.err_count); else passed++;
    total++; if (bus2.locked !== 1'b1) $display("FAIL pre_rst_locked got %b want 1", bus2.locked); else passed++;
    @(negedge clk);
    bus2.data_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus2.locked !== 1'b0) $display("FAIL async_rst_locked got %b want 0", bus2.locked); else passed++;
    total++; if (bus2.err_count !== 2'd0) $display("FAIL async_rst_cnt got %0d want 0", bus2.err_count); else passed++;
    total++; if (bus2.state !== 2'b00) $display("FAIL async_rst_state got %b want 00", bus2.state); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_reseed();
    test_search_and_gap();
    test_saturate_clear_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
